// File: rtl/alu_seq_if.sv
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Operand/result bundle between the control unit and alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] WREG;
   logic [WIDTH-1:0] p;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_hi;
   logic [4:0]       status;

   modport master (
      output start, opcode, WREG, p,
      input  busy, done, res, res_hi, status
   );

   modport slave (
      input  start, opcode, WREG, p,
      output busy, done, res, res_hi, status
   );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU: 13 single-cycle ops plus iterative unsigned
//            multiply / divide / modulo behind a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int WIDTH = 8
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   alu_seq_if.slave     bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] c_OP_ZEROW = 4'd0;
   localparam logic [3:0] c_OP_BNOTW = 4'd1;
   localparam logic [3:0] c_OP_NEGTW = 4'd2;
   localparam logic [3:0] c_OP_INCRW = 4'd3;
   localparam logic [3:0] c_OP_DECRW = 4'd4;
   localparam logic [3:0] c_OP_ANDWP = 4'd5;
   localparam logic [3:0] c_OP_IORWP = 4'd6;
   localparam logic [3:0] c_OP_XORWP = 4'd7;
   localparam logic [3:0] c_OP_ADDWP = 4'd8;
   localparam logic [3:0] c_OP_SUBWP = 4'd9;
   localparam logic [3:0] c_OP_CMPWP = 4'd10;
   localparam logic [3:0] c_OP_SHFLW = 4'd11;
   localparam logic [3:0] c_OP_SHFRW = 4'd12;
   localparam logic [3:0] c_OP_MULWP = 4'd13;
   localparam logic [3:0] c_OP_DIVWP = 4'd14;
   localparam logic [3:0] c_OP_MODWP = 4'd15;

   localparam logic [0:0] c_S_IDLE = 1'b0;
   localparam logic [0:0] c_S_ITER = 1'b1;

   localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [SHW-1:0]   c_LAST     = SHW'(WIDTH-1);

   logic [0:0]       r_state;
   logic [SHW-1:0]   r_cnt;
   logic [3:0]       r_opc;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_res_hi;
   logic [4:0]       r_status;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_neg;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_res_hi;
   logic             w_c;
   logic             w_v;
   logic             w_dz;
   logic             w_iter;
   logic             w_mul_acc;

   logic [WIDTH:0]   w_madd;
   logic [WIDTH:0]   w_dshift;
   logic             w_dge;
   logic [WIDTH-1:0] w_nhi;
   logic [WIDTH-1:0] w_nlo;
   logic [WIDTH-1:0] w_fres;
   logic [WIDTH-1:0] w_fhi;
   logic             w_fc;

   // ---------------------------------------------------------------------
   // Single-cycle datapath, evaluated directly on the bus operands
   // ---------------------------------------------------------------------
   assign w_add = {1'b0, bus.WREG} + {1'b0, bus.p};
   assign w_sub = {1'b0, bus.WREG} - {1'b0, bus.p};
   assign w_neg = {WIDTH{1'b0}} - bus.WREG;

   always_comb begin
      w_res    = '0;
      w_res_hi = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      w_dz     = 1'b0;
      case (bus.opcode)
         c_OP_ZEROW: w_res = '0;
         c_OP_BNOTW: w_res = ~bus.WREG;
         c_OP_NEGTW: begin
            w_res = w_neg;
            w_v   = (bus.WREG == c_MSB_ONLY);
         end
         c_OP_INCRW: w_res = bus.WREG + c_ONE;
         c_OP_DECRW: w_res = bus.WREG - c_ONE;
         c_OP_ANDWP: w_res = bus.WREG & bus.p;
         c_OP_IORWP: w_res = bus.WREG | bus.p;
         c_OP_XORWP: w_res = bus.WREG ^ bus.p;
         c_OP_ADDWP: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (bus.WREG[WIDTH-1] == bus.p[WIDTH-1]) &&
                    (w_add[WIDTH-1] != bus.WREG[WIDTH-1]);
         end
         c_OP_SUBWP: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (bus.WREG[WIDTH-1] != bus.p[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != bus.WREG[WIDTH-1]);
         end
         c_OP_CMPWP: begin
            if (bus.WREG < bus.p)
               w_res = '1;
            else if (bus.WREG > bus.p)
               w_res = c_ONE;
         end
         c_OP_SHFLW: w_res = bus.WREG << bus.p[SHW-1:0];
         c_OP_SHFRW: w_res = bus.WREG >> bus.p[SHW-1:0];
         // Only reached with p==0; non-zero divisors take the iterative path
         c_OP_DIVWP: begin
            w_res    = '1;
            w_res_hi = bus.WREG;
            w_dz     = 1'b1;
         end
         c_OP_MODWP: begin
            w_res    = bus.WREG;
            w_res_hi = '1;
            w_dz     = 1'b1;
         end
         default: w_res = '0;
      endcase
   end

   assign w_mul_acc = (bus.opcode == c_OP_MULWP);
   assign w_iter    = w_mul_acc ||
                      (((bus.opcode == c_OP_DIVWP) || (bus.opcode == c_OP_MODWP)) &&
                       (bus.p != '0));

   // ---------------------------------------------------------------------
   // Iterative step. r_hi/r_lo hold {partial product, multiplier} for MUL
   // and {remainder, dividend/quotient} for DIV/MOD; r_opnd is the
   // multiplicand or divisor.
   // ---------------------------------------------------------------------
   assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_dshift = {r_hi, r_lo[WIDTH-1]};
   assign w_dge    = (w_dshift >= {1'b0, r_opnd});

   always_comb begin
      w_nhi = '0;
      w_nlo = '0;
      if (r_opc == c_OP_MULWP) begin
         w_nhi = w_madd[WIDTH:1];
         w_nlo = {w_madd[0], r_lo[WIDTH-1:1]};
      end else begin
         w_nlo = {r_lo[WIDTH-2:0], w_dge};
         w_nhi = w_dge ? WIDTH'(w_dshift - {1'b0, r_opnd}) : w_dshift[WIDTH-1:0];
      end
   end

   assign w_fres = (r_opc == c_OP_MODWP) ? w_nhi : w_nlo;
   assign w_fhi  = (r_opc == c_OP_MODWP) ? w_nlo : w_nhi;
   assign w_fc   = (r_opc == c_OP_MULWP) && (|w_nhi);

   // ---------------------------------------------------------------------
   // Control and result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= c_S_IDLE;
         r_cnt    <= '0;
         r_opc    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
         r_res    <= '0;
         r_res_hi <= '0;
         r_status <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (bus.start) begin
                  if (w_iter) begin
                     r_state <= c_S_ITER;
                     r_cnt   <= '0;
                     r_opc   <= bus.opcode;
                     r_hi    <= '0;
                     r_opnd  <= w_mul_acc ? bus.WREG : bus.p;
                     r_lo    <= w_mul_acc ? bus.p    : bus.WREG;
                  end else begin
                     r_res    <= w_res;
                     r_res_hi <= w_res_hi;
                     r_status <= {w_dz, w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
                     r_done   <= 1'b1;
                  end
               end
            end
            c_S_ITER: begin
               r_cnt <= r_cnt + 1'b1;
               r_hi  <= w_nhi;
               r_lo  <= w_nlo;
               if (r_cnt == c_LAST) begin
                  r_state  <= c_S_IDLE;
                  r_res    <= w_fres;
                  r_res_hi <= w_fhi;
                  r_status <= {1'b0, 1'b0, w_fc, w_fres[WIDTH-1], (w_fres == '0)};
                  r_done   <= 1'b1;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign bus.busy   = (r_state == c_S_ITER);
   assign bus.done   = r_done;
   assign bus.res    = r_res;
   assign bus.res_hi = r_res_hi;
   assign bus.status = r_status;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8 main, WIDTH=16 corner).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
   logic clk;
   logic rst_n;
   logic rst16_n;
   int   checks;
   int   failures;

   alu_seq_if #(.WIDTH(8))  bus8 ();
   alu_seq_if #(.WIDTH(16)) bus16 ();

   alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n),   .bus(bus8));
   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic [7:0] h;
      logic [4:0] st;
      int         lat;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r, input logic [7:0] h, input logic [4:0] st,
                               input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.r = r; v.h = h; v.st = st; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference model from the arithmetic definitions, using plain integers
   function automatic void ref8(input int op, input int a, input int b,
                                output logic [7:0] r, output logic [7:0] h,
                                output logic [4:0] st, output int lat);
      int  vr, vh, sa, sb, prod;
      bit  c, v, dz;
      vr = 0; vh = 0; c = 0; v = 0; dz = 0; lat = 1;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      case (op)
         0:  vr = 0;
         1:  vr = 255 - a;
         2:  begin vr = (256 - a) % 256; v = (a == 128); end
         3:  vr = (a + 1) % 256;
         4:  vr = (a + 255) % 256;
         5:  vr = a & b;
         6:  vr = a | b;
         7:  vr = a ^ b;
         8:  begin vr = (a + b) % 256; c = (a + b) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
         9:  begin vr = (a - b + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
         10: vr = (a < b) ? 255 : ((a > b) ? 1 : 0);
         11: vr = (a * (1 << (b % 8))) % 256;
         12: vr = a / (1 << (b % 8));
         13: begin prod = a * b; vr = prod % 256; vh = prod / 256; c = (vh != 0); lat = 9; end
         14: if (b == 0) begin vr = 255; vh = a; dz = 1; end
             else begin vr = a / b; vh = a % b; lat = 9; end
         default: if (b == 0) begin vr = a; vh = 255; dz = 1; end
             else begin vr = a % b; vh = a / b; lat = 9; end
      endcase
      r  = 8'(vr);
      h  = 8'(vh);
      st = {dz, v, c, r[7], (r == 8'h00)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue in the current (idle) cycle; returns cycles from accept edge to done
   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output bit bsy, output bit bsy_at_done);
      bus8.start = 1'b1; bus8.opcode = op; bus8.WREG = a; bus8.p = b;
      tick();
      bus8.start = 1'b0;
      lat = 1; bsy = 0;
      while (!bus8.done && lat < 40) begin
         if (bus8.busy) bsy = 1;
         tick();
         lat++;
      end
      bsy_at_done = bus8.busy;
   endtask

   initial begin
      int         lat, dones, n;
      bit         bsy, bsyd;
      logic [7:0] er, eh;
      logic [4:0] est;
      int         elat;
      logic [3:0] rop;
      logic [7:0] ra, rb;

      checks = 0; failures = 0;
      rst_n = 1'b0; rst16_n = 1'b0;
      bus8.start = 1'b0;  bus8.opcode = '0;  bus8.WREG = '0;  bus8.p = '0;
      bus16.start = 1'b0; bus16.opcode = '0; bus16.WREG = '0; bus16.p = '0;
      tick(); tick();
      check("rst res",    32'(bus8.res),    0);
      check("rst res_hi", 32'(bus8.res_hi), 0);
      check("rst status", 32'(bus8.status), 0);
      check("rst busy",   32'(bus8.busy),   0);
      check("rst done",   32'(bus8.done),   0);
      check("rst16 res",  32'(bus16.res),   0);
      rst_n = 1'b1; rst16_n = 1'b1;
      tick();

      // Directed single/multi-cycle vectors
      tbl.push_back(mk(4'd8,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b00101, 1));
      tbl.push_back(mk(4'd8,  8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, 1));
      tbl.push_back(mk(4'd13, 8'hC8, 8'h03, 8'h58, 8'h02, 5'b00100, 9));
      tbl.push_back(mk(4'd14, 8'h64, 8'h07, 8'h0E, 8'h02, 5'b00000, 9));
      tbl.push_back(mk(4'd15, 8'h64, 8'h07, 8'h02, 8'h0E, 5'b00000, 9));
      tbl.push_back(mk(4'd14, 8'h2A, 8'h00, 8'hFF, 8'h2A, 5'b10010, 1));
      tbl.push_back(mk(4'd15, 8'h2A, 8'h00, 8'h2A, 8'hFF, 5'b10000, 1));
      tbl.push_back(mk(4'd9,  8'h00, 8'h01, 8'hFF, 8'h00, 5'b00110, 1));
      tbl.push_back(mk(4'd9,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b01000, 1));
      tbl.push_back(mk(4'd2,  8'h80, 8'h00, 8'h80, 8'h00, 5'b01010, 1));
      tbl.push_back(mk(4'd10, 8'h03, 8'h05, 8'hFF, 8'h00, 5'b00010, 1));
      tbl.push_back(mk(4'd10, 8'h05, 8'h03, 8'h01, 8'h00, 5'b00000, 1));
      tbl.push_back(mk(4'd10, 8'h05, 8'h05, 8'h00, 8'h00, 5'b00001, 1));
      tbl.push_back(mk(4'd11, 8'h81, 8'h09, 8'h02, 8'h00, 5'b00000, 1));
      tbl.push_back(mk(4'd12, 8'h80, 8'h0F, 8'h01, 8'h00, 5'b00000, 1));
      tbl.push_back(mk(4'd0,  8'h55, 8'hAA, 8'h00, 8'h00, 5'b00001, 1));
      tbl.push_back(mk(4'd3,  8'hFF, 8'h00, 8'h00, 8'h00, 5'b00001, 1));
      tbl.push_back(mk(4'd4,  8'h00, 8'h00, 8'hFF, 8'h00, 5'b00010, 1));
      tbl.push_back(mk(4'd1,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b00010, 1));
      tbl.push_back(mk(4'd5,  8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1));
      tbl.push_back(mk(4'd6,  8'hF0, 8'h3C, 8'hFC, 8'h00, 5'b00010, 1));
      tbl.push_back(mk(4'd7,  8'hF0, 8'h3C, 8'hCC, 8'h00, 5'b00010, 1));

      foreach (tbl[i]) begin
         run8(tbl[i].op, tbl[i].a, tbl[i].b, lat, bsy, bsyd);
         check($sformatf("vec%0d latency", i), 32'(lat),            32'(tbl[i].lat));
         check($sformatf("vec%0d res", i),     32'(bus8.res),       32'(tbl[i].r));
         check($sformatf("vec%0d res_hi", i),  32'(bus8.res_hi),    32'(tbl[i].h));
         check($sformatf("vec%0d status", i),  32'(bus8.status),    32'(tbl[i].st));
         check($sformatf("vec%0d busy", i),    32'(bsy),            32'(tbl[i].lat > 1));
         check($sformatf("vec%0d busy@done", i), 32'(bsyd),         0);
      end
      tick();
      check("done one-shot", 32'(bus8.done), 0);

      // start during ITER ignored; start in done cycle accepted
      bus8.start = 1'b1; bus8.opcode = 4'd13; bus8.WREG = 8'hC8; bus8.p = 8'h03;
      tick();
      bus8.start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 8; c++) begin
         if (bus8.done) dones++;
         if (c == 3) begin
            bus8.start = 1'b1; bus8.opcode = 4'd8; bus8.WREG = 8'h01; bus8.p = 8'h01;
         end
         tick();
         bus8.start = 1'b0;
      end
      check("ignored start: done at N+9", 32'(bus8.done), 1);
      check("ignored start: early dones", 32'(dones), 0);
      check("ignored start: mul res", 32'(bus8.res), 32'h58);
      bus8.start = 1'b1; bus8.opcode = 4'd8; bus8.WREG = 8'h01; bus8.p = 8'h02;
      tick();
      bus8.start = 1'b0;
      check("back-to-back done", 32'(bus8.done), 1);
      check("back-to-back res",  32'(bus8.res),  32'h03);
      tick();
      check("back-to-back single pulse", 32'(bus8.done), 0);

      // Reset aborts an in-flight divide
      bus8.start = 1'b1; bus8.opcode = 4'd14; bus8.WREG = 8'h64; bus8.p = 8'h07;
      tick();
      bus8.start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort res",    32'(bus8.res),    0);
      check("abort res_hi", 32'(bus8.res_hi), 0);
      check("abort status", 32'(bus8.status), 0);
      check("abort busy",   32'(bus8.busy),   0);
      check("abort done",   32'(bus8.done),   0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus8.done) dones++;
      end
      check("abort no done", 32'(dones), 0);

      // Randomised against the reference model
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 8'($urandom_range(0, 255));
         rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         ref8(int'(rop), int'(ra), int'(rb), er, eh, est, elat);
         run8(rop, ra, rb, lat, bsy, bsyd);
         check($sformatf("rnd%0d op%0d %0h,%0h latency", i, rop, ra, rb), 32'(lat), 32'(elat));
         check($sformatf("rnd%0d op%0d %0h,%0h res", i, rop, ra, rb),     32'(bus8.res), 32'(er));
         check($sformatf("rnd%0d op%0d %0h,%0h res_hi", i, rop, ra, rb),  32'(bus8.res_hi), 32'(eh));
         check($sformatf("rnd%0d op%0d %0h,%0h status", i, rop, ra, rb),  32'(bus8.status), 32'(est));
      end

      // WIDTH=16 full-scale multiply
      bus16.start = 1'b1; bus16.opcode = 4'd13; bus16.WREG = 16'hFFFF; bus16.p = 16'hFFFF;
      tick();
      bus16.start = 1'b0;
      n = 1;
      while (!bus16.done && n < 60) begin
         tick();
         n++;
      end
      check("mul16 latency", 32'(n),              17);
      check("mul16 res",     32'(bus16.res),      32'h0001);
      check("mul16 res_hi",  32'(bus16.res_hi),   32'hFFFE);
      check("mul16 status",  32'(bus16.status),   32'b00100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
